mux_pipe_n: RTL and testbench
=============================

MUX_PIPE_N -- requirements
Module: mux_pipe_n

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width per channel, 1..256.
REQ-002 SHALL have parameter NUM_IN, default 32: input channel count, 2..64.
REQ-003 SHALL have parameter SEL_W, default 5: select width, equal to ceil(log2(NUM_IN)).
REQ-004 SHALL have port clk  in  1  the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_data  in  NUM_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port in_vld  in  NUM_IN  per-channel valid.
REQ-008 SHALL have port in_rdy  out  NUM_IN  per-channel ready, at most one bit high per cycle.
REQ-009 SHALL have port sel  in  SEL_W  channel index used in explicit mode.
REQ-010 SHALL have port arb_mode  in  1  0 = explicit select, 1 = round-robin.
REQ-011 SHALL have port out_data  out  WIDTH  head-of-buffer data.
REQ-012 SHALL have port out_chan  out  SEL_W  source channel of out_data.
REQ-013 SHALL have port out_vld  out  1  output valid.
REQ-014 SHALL have port out_rdy  in  1  downstream ready.

Function
REQ-015 SHALL hold accepted words in a 2-entry FIFO of {data, channel}; occupancy count takes values 0..2.
REQ-016 SHALL define space = (count < 2), derived from registered state only; there SHALL be no combinational path from out_rdy to in_rdy.
REQ-017 Explicit mode: SHALL drive in_rdy[sel] = space when sel < NUM_IN, with all other in_rdy bits 0; when sel >= NUM_IN, all in_rdy bits SHALL be 0.
REQ-018 Round-robin mode: the granted channel SHALL be the first k with in_vld[k]=1, searching ptr, ptr+1, ... modulo NUM_IN.
REQ-019 Round-robin mode: SHALL drive in_rdy[granted] = space, with all other in_rdy bits 0; with no valid channel, all in_rdy bits SHALL be 0.
REQ-020 A transfer SHALL occur on a cycle where in_vld[k] and in_rdy[k] are both high; it SHALL write in_data[k] and k into the FIFO tail.
REQ-021 Latency SHALL be 1 cycle: a word accepted at edge n SHALL be visible on out_data at n+1 if the FIFO was empty.
REQ-022 SHALL drive out_vld = (count > 0); a pop SHALL occur on out_vld & out_rdy.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and preserve order; sustained throughput SHALL be 1 word/cycle while out_rdy=1.
REQ-024 Round-robin pointer ptr SHALL update to (k+1) mod NUM_IN only on a round-robin transfer from channel k; it SHALL hold otherwise, including in explicit mode.
REQ-025 arb_mode and sel SHALL be sampled every cycle, so a change takes effect in the same cycle; words already buffered SHALL be unaffected.
REQ-026 When count==0, out_data and out_chan SHALL hold their last value (0 after reset).
REQ-027 When count==2, no push SHALL occur even if out_rdy=1 in that cycle; space frees on the following cycle.

Reset
REQ-028 On rst low, the block SHALL asynchronously clear count=0, ptr=0, and all FIFO entries, out_data and out_chan to 0.
REQ-029 During reset, out_vld and all in_rdy bits SHALL be 0.
REQ-030 Buffered words SHALL be discarded on reset asserted mid-operation.
REQ-031 Operation SHALL resume on the first rising edge after rst deasserts.

Verification
REQ-032 SHALL verify explicit mode: NUM_IN=32, WIDTH=32, sel=17, in_data ch17=0xDEADBEEF, in_vld=all ones, out_rdy=1 -> only in_rdy[17]=1; next cycle out_data=0xDEADBEEF, out_chan=17.
REQ-033 SHALL verify round-robin: in_vld={3,9,30} held high, out_rdy=1 -> grants 3,9,30,3,9 on consecutive cycles, one word/cycle.
REQ-034 SHALL verify backpressure: out_rdy=0 with ch5 valid -> two words accepted, then in_rdy=0; out_rdy=1 -> words drain in order, in_rdy returns next cycle.
REQ-035 SHALL verify out-of-range select: NUM_IN=20, sel=25 -> all in_rdy=0, out_vld stays 0.
REQ-036 SHALL verify reset mid-burst: count=2, assert rst between edges -> out_vld=0 immediately; after release ptr=0, so ch0 wins if valid.
REQ-037 SHALL verify mode switch: arb_mode 1->0 after a grant to ch7 with ptr=8, then back to 1 -> explicit transfers leave ptr=8 and the search resumes at 8.

Source files
------------

// File: rtl/mux_pipe_n.sv
// mux_pipe_n: N-to-1 channel multiplexer feeding a 2-entry {data, channel}
// output buffer. It has two arbitration modes: explicit select and round-robin.
// in_rdy depends only on registered occupancy and the current inputs.
// It never depends on out_rdy, so backpressure does not ripple upstream
// combinationally.
module mux_pipe_n #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 32,
    parameter int SEL_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_vld,
    output logic [NUM_IN-1:0]       in_rdy,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    arb_mode,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_chan,
    output logic                    out_vld,
    input  logic                    out_rdy
);

    localparam logic [SEL_W:0]   NUM_IN_W = (SEL_W+1)'(NUM_IN);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_IN - 1);

    // Buffer is kept as head/tail registers so the head doubles as the
    // registered output and naturally holds its last value when empty.
    logic [1:0]       count_r;
    logic [SEL_W-1:0] ptr_r;
    logic [WIDTH-1:0] head_data_r;
    logic [SEL_W-1:0] head_chan_r;
    logic [WIDTH-1:0] tail_data_r;
    logic [SEL_W-1:0] tail_chan_r;

    logic             rr_found_s;
    logic [SEL_W-1:0] rr_gnt_s;
    logic             gnt_vld_s;
    logic [SEL_W-1:0] gnt_s;
    logic             space_s;
    logic             push_s;
    logic             pop_s;
    logic [WIDTH-1:0] push_data_s;
    logic [SEL_W-1:0] ptr_nxt_s;
    logic [1:0]       count_nxt_s;
    logic [WIDTH-1:0] head_data_nxt_s;
    logic [SEL_W-1:0] head_chan_nxt_s;
    logic [WIDTH-1:0] tail_data_nxt_s;
    logic [SEL_W-1:0] tail_chan_nxt_s;

    // Round-robin search: first valid channel starting at ptr_r, wrapping at NUM_IN.
    always_comb begin
        logic [SEL_W:0] sum_v;
        logic [SEL_W:0] idx_v;
        logic           take_v;
        rr_found_s = 1'b0;
        rr_gnt_s   = {SEL_W{1'b0}};
        sum_v      = {(SEL_W+1){1'b0}};
        idx_v      = {(SEL_W+1){1'b0}};
        take_v     = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            sum_v      = {1'b0, ptr_r} + (SEL_W+1)'(i);
            idx_v      = (sum_v >= NUM_IN_W) ? (sum_v - NUM_IN_W) : sum_v;
            take_v     = !rr_found_s && in_vld[idx_v[SEL_W-1:0]];
            rr_gnt_s   = take_v ? idx_v[SEL_W-1:0] : rr_gnt_s;
            rr_found_s = rr_found_s | take_v;
        end
    end

    // Grant selection for the current mode; explicit select is rejected when out of range.
    always_comb begin
        if (arb_mode) begin
            gnt_vld_s = rr_found_s;
            gnt_s     = rr_gnt_s;
        end else begin
            gnt_vld_s = ({1'b0, sel} < NUM_IN_W);
            gnt_s     = sel;
        end
    end

    assign space_s = (count_r < 2'd2);

    // One-hot ready toward the granted channel, forced low while reset is asserted.
    always_comb begin
        in_rdy         = {NUM_IN{1'b0}};
        in_rdy[gnt_s]  = gnt_vld_s & space_s & rst;
    end

    assign push_s      = |(in_rdy & in_vld);
    assign pop_s       = (count_r != 2'd0) & out_rdy;
    assign push_data_s = in_data[int'(gnt_s)*WIDTH +: WIDTH];
    assign ptr_nxt_s   = (gnt_s == LAST_CH) ? {SEL_W{1'b0}} : (gnt_s + SEL_W'(1));

    // Buffer next-state: push fills head when empty, else tail; pop promotes tail.
    always_comb begin
        count_nxt_s     = count_r;
        head_data_nxt_s = head_data_r;
        head_chan_nxt_s = head_chan_r;
        tail_data_nxt_s = tail_data_r;
        tail_chan_nxt_s = tail_chan_r;
        case ({push_s, pop_s})
            2'b10: begin
                if (count_r == 2'd0) begin
                    head_data_nxt_s = push_data_s;
                    head_chan_nxt_s = gnt_s;
                    count_nxt_s     = 2'd1;
                end else begin
                    tail_data_nxt_s = push_data_s;
                    tail_chan_nxt_s = gnt_s;
                    count_nxt_s     = 2'd2;
                end
            end
            2'b01: begin
                if (count_r == 2'd2) begin
                    head_data_nxt_s = tail_data_r;
                    head_chan_nxt_s = tail_chan_r;
                end else begin
                    head_data_nxt_s = head_data_r;
                    head_chan_nxt_s = head_chan_r;
                end
                count_nxt_s = count_r - 2'd1;
            end
            2'b11: begin
                // A push implies count was 1 here, so the new word becomes the head.
                head_data_nxt_s = push_data_s;
                head_chan_nxt_s = gnt_s;
            end
            default: begin
                count_nxt_s = count_r;
            end
        endcase
    end

    // State registers: buffer, occupancy and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r     <= 2'd0;
            ptr_r       <= {SEL_W{1'b0}};
            head_data_r <= {WIDTH{1'b0}};
            head_chan_r <= {SEL_W{1'b0}};
            tail_data_r <= {WIDTH{1'b0}};
            tail_chan_r <= {SEL_W{1'b0}};
        end else begin
            count_r     <= count_nxt_s;
            head_data_r <= head_data_nxt_s;
            head_chan_r <= head_chan_nxt_s;
            tail_data_r <= tail_data_nxt_s;
            tail_chan_r <= tail_chan_nxt_s;
            if (push_s && arb_mode) begin
                ptr_r <= ptr_nxt_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    assign out_data = head_data_r;
    assign out_chan = head_chan_r;
    assign out_vld  = (count_r != 2'd0);

endmodule

// File: tb/tb_mux_pipe_n.sv
// Testbench for mux_pipe_n. It checks the design against a queue-based
// reference model and adds directed scenarios.
module tb_mux_pipe_n;

    localparam int N  = 32;
    localparam int W  = 32;
    localparam int SW = 5;
    localparam int N2 = 20;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_vld;
    logic [N-1:0]   in_rdy;
    logic [SW-1:0]  sel;
    logic           arb_mode;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_chan;
    logic           out_vld;
    logic           out_rdy;

    logic [N2*W-1:0] d20_in_data;
    logic [N2-1:0]   d20_in_vld;
    logic [N2-1:0]   d20_in_rdy;
    logic [SW-1:0]   d20_sel;
    logic            d20_arb_mode;
    logic [W-1:0]    d20_out_data;
    logic [SW-1:0]   d20_out_chan;
    logic            d20_out_vld;
    logic            d20_out_rdy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] d;
        int           c;
    } ent_t;

    ent_t         m_q[$];
    int           m_ptr;
    logic [W-1:0] m_last_d;
    int           m_last_c;

    always #5 clk = ~clk;

    mux_pipe_n #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
        .sel(sel), .arb_mode(arb_mode), .out_data(out_data), .out_chan(out_chan),
        .out_vld(out_vld), .out_rdy(out_rdy)
    );

    mux_pipe_n #(.WIDTH(W), .NUM_IN(N2), .SEL_W(SW)) dut20 (
        .clk(clk), .rst(rst), .in_data(d20_in_data), .in_vld(d20_in_vld), .in_rdy(d20_in_rdy),
        .sel(d20_sel), .arb_mode(d20_arb_mode), .out_data(d20_out_data), .out_chan(d20_out_chan),
        .out_vld(d20_out_vld), .out_rdy(d20_out_rdy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            in_data[i*W +: W] = $urandom;
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ptr    = 0;
        m_last_d = '0;
        m_last_c = 0;
    endtask

    // Expected ready vector, derived from the arbitration rules and the model's occupancy.
    function automatic logic [N-1:0] model_rdy();
        logic [N-1:0] r;
        bit           space;
        r     = '0;
        space = (m_q.size() < 2);
        if (!arb_mode) begin
            if (int'(sel) < N) r[sel] = space;
        end else begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (in_vld[k]) begin
                    r[k] = space;
                    break;
                end
            end
        end
        return r;
    endfunction

    // One clock: compare mid-cycle, then advance the model across the rising edge.
    task automatic step();
        logic [N-1:0] er;
        int           k;
        #1;
        er = model_rdy();
        chk("in_rdy", 64'(in_rdy), 64'(er));
        chk("out_vld", 64'(out_vld), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            m_last_d = m_q[0].d;
            m_last_c = m_q[0].c;
        end
        chk("out_data", 64'(out_data), 64'(m_last_d));
        chk("out_chan", 64'(out_chan), 64'(m_last_c));
        @(posedge clk);
        k = -1;
        for (int i = 0; i < N; i++) begin
            if (er[i] && in_vld[i]) k = i;
        end
        if (m_q.size() > 0 && out_rdy) void'(m_q.pop_front());
        if (k >= 0) begin
            m_q.push_back('{d: in_data[k*W +: W], c: k});
            if (arb_mode) m_ptr = (k + 1) % N;
        end
        @(negedge clk);
    endtask

    initial begin
        int rr_seq[5];
        logic [W-1:0] d19;
        rr_seq = '{3, 9, 30, 3, 9};

        rst = 1'b0;
        in_vld = '1; sel = '0; arb_mode = 1'b0; out_rdy = 1'b1;
        rand_data();
        d20_in_vld = '1; d20_sel = 5'd25; d20_arb_mode = 1'b0; d20_out_rdy = 1'b1;
        for (int i = 0; i < N2; i++) d20_in_data[i*W +: W] = $urandom;
        model_reset();

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        chk("rst_in_rdy", 64'(in_rdy), 64'd0);
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_chan", 64'(out_chan), 64'd0);
        chk("rst_d20_in_rdy", 64'(d20_in_rdy), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Explicit select of channel 17
        sel = 5'd17; in_vld = '1; out_rdy = 1'b1; rand_data();
        in_data[17*W +: W] = 32'hDEADBEEF;
        #1 chk("expl_rdy17", 64'(in_rdy), 64'(32'h0002_0000));
        step();
        in_vld = '0;
        #1;
        chk("expl_data", 64'(out_data), 64'(32'hDEADBEEF));
        chk("expl_chan", 64'(out_chan), 64'd17);
        step(); step();

        // Round-robin over channels 3, 9, 30
        arb_mode = 1'b1;
        in_vld = '0; in_vld[3] = 1'b1; in_vld[9] = 1'b1; in_vld[30] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            #1 chk("rr_grant", 64'(in_rdy), 64'(1) << rr_seq[i]);
            step();
        end
        in_vld = '0;
        step(); step();

        // Backpressure on channel 5
        arb_mode = 1'b0; sel = 5'd5; in_vld = '0; in_vld[5] = 1'b1; out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            #1 chk("bp_fill", 64'(in_rdy), (i < 2) ? 64'h20 : 64'h0);
            step();
        end
        out_rdy = 1'b1; rand_data();
        #1 chk("bp_full_rdy", 64'(in_rdy), 64'h0);
        step();
        rand_data();
        #1 chk("bp_reopen", 64'(in_rdy), 64'h20);
        step();
        in_vld = '0;
        step(); step(); step();

        // Out-of-range select on the 20-channel instance
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("oor_in_rdy", 64'(d20_in_rdy), 64'd0);
            chk("oor_out_vld", 64'(d20_out_vld), 64'd0);
            step();
        end
        d20_sel = 5'd19;
        d19 = d20_in_data[19*W +: W];
        #1 chk("sel19_rdy", 64'(d20_in_rdy), 64'(20'h80000));
        step();
        d20_sel = 5'd25;
        #1;
        chk("sel19_vld", 64'(d20_out_vld), 64'd1);
        chk("sel19_chan", 64'(d20_out_chan), 64'd19);
        chk("sel19_data", 64'(d20_out_data), 64'(d19));
        step();

        // Reset asserted mid-burst with two words buffered
        arb_mode = 1'b1; in_vld = '0; in_vld[4] = 1'b1; out_rdy = 1'b0;
        step(); rand_data(); step(); step();
        #1 chk("burst_vld", 64'(out_vld), 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(out_vld), 64'd0);
        chk("mid_rst_rdy", 64'(in_rdy), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        in_vld = '0; in_vld[0] = 1'b1; in_vld[5] = 1'b1; out_rdy = 1'b1; rand_data();
        #1 chk("post_rst_ch0", 64'(in_rdy), 64'h1);
        step();
        in_vld = '0;
        step(); step();

        // Mode switch: grant ch7 (ptr=8), explicit transfers, then resume at 8
        arb_mode = 1'b1; in_vld = '0; in_vld[7] = 1'b1; rand_data();
        #1 chk("ms_grant7", 64'(in_rdy), 64'h80);
        step();
        arb_mode = 1'b0; sel = 5'd2;
        in_vld = '0; in_vld[2] = 1'b1; in_vld[8] = 1'b1; in_vld[12] = 1'b1;
        #1 chk("ms_expl2", 64'(in_rdy), 64'h4);
        step(); rand_data(); step();
        arb_mode = 1'b1; rand_data();
        #1 chk("ms_resume8", 64'(in_rdy), 64'h100);
        step();
        rand_data();
        #1 chk("ms_next12", 64'(in_rdy), 64'h1000);
        step();
        in_vld = '0;
        step(); step();

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            in_vld   = $urandom & $urandom;
            sel      = SW'($urandom_range(0, N - 1));
            arb_mode = 1'($urandom_range(0, 1));
            out_rdy  = ($urandom_range(0, 3) != 0);
            rand_data();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
